pe_accum: RTL and testbench

PE_ACCUM -- requirements
Module: pe_accum

---
 rtl/bitblade_pkg.sv | 12 +
 rtl/pe_sat_add.sv | 31 +++
 rtl/pe_accum.sv | 69 ++++++
 tb/tb_pe_accum.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bitblade_pkg.sv
// Shared defaults and FSM state encoding for the PE accumulate stage.
package bitblade_pkg;
    localparam int IN_W_DEF  = 20;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/pe_sat_add.sv
// Sign-extend a partial sum and add it to the accumulator; clamps on signed
// overflow when PE_ACCUM_SAT_EN is defined, otherwise wraps and flags nothing.
module pe_sat_add #(
    parameter int IN_W  = 20,
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  addend,
    input  logic             first,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    logic [ACC_W-1:0] base, ext, raw;

    // first beat of a group starts from zero rather than the stale accumulator
    assign base = first ? '0 : acc;
    assign ext  = ACC_W'($signed(addend));
    assign raw  = base + ext;

`ifdef PE_ACCUM_SAT_EN
    logic wrap_ovf;
    assign wrap_ovf = (base[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
    assign ovf      = wrap_ovf;
    assign sum      = !wrap_ovf      ? raw :
                      base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign ovf = 1'b0;
    assign sum = raw;
`endif
endmodule

// File: rtl/pe_accum.sv
// Group accumulator: sums signed beats until in_last, then holds the result
// until taken. Optional clamping via PE_ACCUM_SAT_EN.
module pe_accum
    import bitblade_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);
    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, sum;
    logic [CNT_W-1:0] beats;
    logic             ovf, add_ovf, accept, first;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign first     = (state == IDLE);
    assign out_data  = acc;
    assign out_beats = beats;
    assign out_ovf   = ovf;

    pe_sat_add #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add (
        .acc    (acc),
        .addend (in_data),
        .first  (first),
        .sum    (sum),
        .ovf    (add_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACC: if (accept) state_nxt = in_last ? HOLD : ACC;
            HOLD:      if (out_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            beats <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc <= sum;
                // counter sticks at all-ones instead of wrapping
                if (first)      beats <= CNT_W'(1);
                else if (~&beats) beats <= beats + CNT_W'(1);
                ovf <= first ? add_ovf : (ovf | add_ovf);
            end
        end
    end
endmodule

// File: tb/tb_pe_accum.sv
// Self-checking bench for pe_accum: directed table, corner sequences and
// randomized groups against an arithmetic reference model.
module tb_pe_accum;
    localparam int IN_W  = 20;
    localparam int ACC_W = 24;
    localparam int CNT_W = 6;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid, in_ready, in_last;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid, out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [CNT_W-1:0]        out_beats;
    logic                    out_ovf;

    int checks = 0;
    int failures = 0;
    int beats_q[$];

    pe_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: running sum with clamp or two's-complement wrap per beat
    task automatic model(output longint d, output int b, output bit o);
        longint s = 0;
        o = 1'b0;
        foreach (beats_q[i]) begin
            s = s + beats_q[i];
`ifdef PE_ACCUM_SAT_EN
            if (s > ACC_MAX) begin s = ACC_MAX; o = 1'b1; end
            if (s < ACC_MIN) begin s = ACC_MIN; o = 1'b1; end
`else
            while (s > ACC_MAX) s = s - (longint'(1) <<< ACC_W);
            while (s < ACC_MIN) s = s + (longint'(1) <<< ACC_W);
`endif
        end
        d = s;
        b = (beats_q.size() > (2**CNT_W - 1)) ? (2**CNT_W - 1) : beats_q.size();
    endtask

    // send beats_q as one group, check result, hold for 'hold' cycles with a
    // stray beat offered, then release
    task automatic run_group(input string name, input longint ed, input int eb,
                             input bit eo, input int hold);
        longint d0;
        for (int i = 0; i < beats_q.size(); i++) begin
            int g = 0;
            in_valid = 1'b1;
            in_data  = IN_W'(beats_q[i]);
            in_last  = (i == beats_q.size() - 1);
            while (!in_ready && g < 50) begin tick(); g++; end
            if (g == 50) chk({name, "_ready_timeout"}, 0, 1);
            tick();
            if (i < beats_q.size() - 1 && i < 2) chk({name, "_busy_valid"}, out_valid, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({name, "_latency"}, out_valid, 1);
        chk({name, "_data"}, out_data, ed);
        chk({name, "_beats"}, out_beats, eb);
        chk({name, "_ovf"}, out_ovf, eo);
        d0 = out_data;
        in_valid = (hold > 0);
        in_data  = IN_W'(99);
        in_last  = 1'b1;
        for (int h = 0; h < hold; h++) begin
            chk({name, "_hold_ready"}, in_ready, 0);
            tick();
            chk({name, "_hold_valid"}, out_valid, 1);
            chk({name, "_hold_data"}, out_data, d0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk({name, "_release"}, out_valid, 0);
        chk({name, "_idle_ready"}, in_ready, 1);
    endtask

    typedef struct {
        int     n;
        int     v[4];
        longint exp_data;
        int     exp_beats;
        int     hold;
    } vec_t;

    initial begin
        vec_t   tbl[5];
        longint ed;
        int     eb;
        bit     eo;

        tbl[0] = '{3, '{5, -3, 12, 0}, 14, 3, 0};
        tbl[1] = '{1, '{-7, 0, 0, 0}, -7, 1, 0};
        tbl[2] = '{2, '{524287, -524288, 0, 0}, -1, 2, 4};
        tbl[3] = '{3, '{-524288, -524288, 1000, 0}, -1047576, 3, 1};
        tbl[4] = '{4, '{1, 2, 3, 4}, 10, 4, 2};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", out_data, 0);
        chk("rst_beats", out_beats, 0);
        chk("rst_ovf", out_ovf, 0);
        reset = 1'b1;
        tick();

        foreach (tbl[k]) begin
            beats_q = {};
            for (int j = 0; j < tbl[k].n; j++) beats_q.push_back(tbl[k].v[j]);
            run_group($sformatf("tbl%0d", k), tbl[k].exp_data, tbl[k].exp_beats, 1'b0, tbl[k].hold);
        end

        // counter saturates, sum keeps counting
        beats_q = {};
        repeat (70) beats_q.push_back(1);
        run_group("sat_cnt", 70, 63, 1'b0, 0);

        // positive and negative accumulator overflow
        beats_q = {};
        repeat (20) beats_q.push_back(524287);
`ifdef PE_ACCUM_SAT_EN
        run_group("ovf_pos", 8388607, 20, 1'b1, 0);
`else
        run_group("ovf_pos", -6291476, 20, 1'b0, 0);
`endif
        beats_q = {};
        repeat (20) beats_q.push_back(-524288);
`ifdef PE_ACCUM_SAT_EN
        run_group("ovf_neg", -8388608, 20, 1'b1, 0);
`else
        run_group("ovf_neg", 6291456, 20, 1'b0, 0);
`endif
        // ovf must not leak into the next group
        beats_q = {3};
        run_group("ovf_clear", 3, 1, 1'b0, 0);

        // reset in the middle of a group
        in_valid = 1'b1; in_last = 1'b0;
        in_data = IN_W'(40); tick();
        in_data = IN_W'(50); tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_data", out_data, 0);
        chk("midrst_beats", out_beats, 0);
        tick();
        chk("midrst_no_accept", out_beats, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        beats_q = {1, 1};
        run_group("post_rst", 2, 2, 1'b0, 0);

        // randomized groups against the model
        for (int r = 0; r < 20; r++) begin
            int n = $urandom_range(1, 8);
            beats_q = {};
            repeat (n) beats_q.push_back(int'($urandom_range(0, 1048575)) - 524288);
            model(ed, eb, eo);
            run_group($sformatf("rnd%0d", r), ed, eb, eo, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
